// File: rtl/peripheral_mailbox_if.sv
// Core-side command/response channel of the peripheral mailbox.
// The core drives commands (master); the mailbox returns one registered response (slave).
interface peripheral_mailbox_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [1:0]            to_peripheral;
   logic [DATA_WIDTH-1:0] to_peripheral_data;
   logic                  to_peripheral_valid;
   logic [1:0]            from_peripheral;
   logic [DATA_WIDTH-1:0] from_peripheral_data;
   logic                  from_peripheral_valid;

   modport master (
      output to_peripheral, to_peripheral_data, to_peripheral_valid,
      input  from_peripheral, from_peripheral_data, from_peripheral_valid
   );

   modport slave (
      input  to_peripheral, to_peripheral_data, to_peripheral_valid,
      output from_peripheral, from_peripheral_data, from_peripheral_valid
   );
endinterface

// File: rtl/peripheral_mailbox.sv
// Peripheral mailbox: decodes core PUSH/POP/STATUS commands against a TX FIFO drained by
// the host and an RX FIFO filled by the host, returning one registered response per command.
module peripheral_mailbox #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned FIFO_DEPTH_BITS = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   peripheral_mailbox_if.slave   core,
   input  logic [DATA_WIDTH-1:0] host_rx_data,
   input  logic                  host_rx_valid,
   output logic                  host_rx_ready,
   output logic [DATA_WIDTH-1:0] host_tx_data,
   output logic                  host_tx_valid,
   input  logic                  host_tx_ready
);

   localparam int unsigned Depth = 2 ** FIFO_DEPTH_BITS;
   localparam int unsigned CntW  = FIFO_DEPTH_BITS + 1;

   typedef enum logic [1:0] {OpNop, OpPush, OpPop, OpStatus} op_e;
   typedef enum logic [1:0] {RespNone, RespAck, RespData, RespErr} resp_e;

   logic [DATA_WIDTH-1:0]      tx_mem_q [Depth];
   logic [DATA_WIDTH-1:0]      rx_mem_q [Depth];
   logic [FIFO_DEPTH_BITS-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [FIFO_DEPTH_BITS-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [CntW-1:0]            tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, tx_cnt_inc;
   logic                       ovf_q, ovf_d, unf_q, unf_d;
   resp_e                      resp_code_q, resp_code_d;
   logic [DATA_WIDTH-1:0]      resp_data_q, resp_data_d;
   logic                       resp_valid_q, resp_valid_d;

   op_e                   op;
   logic                  cmd_push, cmd_pop, cmd_status;
   logic                  tx_full, tx_empty, rx_full, rx_empty;
   logic                  tx_we, tx_re, rx_we, rx_re;
   logic [DATA_WIDTH-1:0] status_word;

   assign op         = op_e'(core.to_peripheral);
   assign cmd_push   = core.to_peripheral_valid && (op == OpPush);
   assign cmd_pop    = core.to_peripheral_valid && (op == OpPop);
   assign cmd_status = core.to_peripheral_valid && (op == OpStatus);

   assign tx_full  = (tx_cnt_q == CntW'(Depth));
   assign tx_empty = (tx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == CntW'(Depth));
   assign rx_empty = (rx_cnt_q == '0);

   // All full/empty decisions use start-of-cycle state, so same-cycle host activity never rescues a command.
   assign tx_we = cmd_push && !tx_full;
   assign tx_re = !tx_empty && host_tx_ready;
   assign rx_we = host_rx_valid && !rx_full;
   assign rx_re = cmd_pop && !rx_empty;

   assign tx_cnt_inc = tx_cnt_q + CntW'(1);

   assign host_tx_valid = !tx_empty;
   assign host_tx_data  = tx_mem_q[tx_rd_q];
   assign host_rx_ready = !rx_full;

   assign core.from_peripheral       = resp_code_q;
   assign core.from_peripheral_data  = resp_data_q;
   assign core.from_peripheral_valid = resp_valid_q;

   always_comb begin
      status_word        = '0;
      status_word[0]     = tx_full;
      status_word[1]     = tx_empty;
      status_word[2]     = rx_full;
      status_word[3]     = rx_empty;
      status_word[4]     = ovf_q;
      status_word[5]     = unf_q;
      status_word[15:8]  = 8'(tx_cnt_q);
      status_word[23:16] = 8'(rx_cnt_q);
   end

   always_comb begin
      tx_wr_d  = tx_wr_q + FIFO_DEPTH_BITS'(tx_we);
      tx_rd_d  = tx_rd_q + FIFO_DEPTH_BITS'(tx_re);
      rx_wr_d  = rx_wr_q + FIFO_DEPTH_BITS'(rx_we);
      rx_rd_d  = rx_rd_q + FIFO_DEPTH_BITS'(rx_re);
      tx_cnt_d = tx_cnt_q + CntW'(tx_we) - CntW'(tx_re);
      rx_cnt_d = rx_cnt_q + CntW'(rx_we) - CntW'(rx_re);
      // STATUS clears the sticky flags; it cannot coincide with a PUSH or POP.
      ovf_d    = cmd_status ? 1'b0 : (ovf_q || (cmd_push && tx_full));
      unf_d    = cmd_status ? 1'b0 : (unf_q || (cmd_pop && rx_empty));
   end

   always_comb begin
      resp_code_d  = RespNone;
      resp_data_d  = '0;
      resp_valid_d = 1'b0;
      if (core.to_peripheral_valid) begin
         case (op)
            OpPush: begin
               resp_valid_d = 1'b1;
               if (tx_full) begin
                  resp_code_d = RespErr;
               end else begin
                  resp_code_d = RespAck;
                  resp_data_d = DATA_WIDTH'(tx_cnt_inc);
               end
            end
            OpPop: begin
               resp_valid_d = 1'b1;
               if (rx_empty) begin
                  resp_code_d = RespErr;
               end else begin
                  resp_code_d = RespData;
                  resp_data_d = rx_mem_q[rx_rd_q];
               end
            end
            OpStatus: begin
               resp_valid_d = 1'b1;
               resp_code_d  = RespData;
               resp_data_d  = status_word;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_wr_q      <= '0;
         tx_rd_q      <= '0;
         rx_wr_q      <= '0;
         rx_rd_q      <= '0;
         tx_cnt_q     <= '0;
         rx_cnt_q     <= '0;
         ovf_q        <= 1'b0;
         unf_q        <= 1'b0;
         resp_code_q  <= RespNone;
         resp_data_q  <= '0;
         resp_valid_q <= 1'b0;
      end else begin
         tx_wr_q      <= tx_wr_d;
         tx_rd_q      <= tx_rd_d;
         rx_wr_q      <= rx_wr_d;
         rx_rd_q      <= rx_rd_d;
         tx_cnt_q     <= tx_cnt_d;
         rx_cnt_q     <= rx_cnt_d;
         ovf_q        <= ovf_d;
         unf_q        <= unf_d;
         resp_code_q  <= resp_code_d;
         resp_data_q  <= resp_data_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   // Storage needs no reset: pointers and counts define which entries are live.
   always_ff @(posedge clock) begin
      if (tx_we) tx_mem_q[tx_wr_q] <= core.to_peripheral_data;
      if (rx_we) rx_mem_q[rx_wr_q] <= host_rx_data;
   end

endmodule
